// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the latched request.
package lsu_pkg;

    localparam int unsigned MEM_BYTES_DEF = 256;
    localparam int unsigned XLEN          = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        H0   = 3'd2,
        H1   = 3'd3,
        ERR  = 3'd4,
        RESP = 3'd5
    } state_e;

    typedef struct packed {
        logic              we;
        size_e             size;
        logic              uns;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
    } req_t;

    // Number of bytes an access of the given size touches (illegal treated as a word).
    function automatic logic [2:0] size_bytes(input size_e s);
        case (s)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of raw load data according to the access size.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] ext_c
);

    always_comb begin
        ext_c = raw;
        case (size_e'(size))
            SZ_BYTE: ext_c = {{24{raw[7] & ~uns}}, raw[7:0]};
            SZ_HALF: ext_c = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: ext_c = raw;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a 256x8 big-endian data memory; halfwords are split into two byte accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_we,
    output logic            mem_byte_src,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    logic [7:0]      hi_q, hi_d;
    logic            resp_valid_d, resp_err_d;
    logic [XLEN-1:0] resp_rdata_d;
    logic            mem_we_d, mem_byte_src_d;
    logic [XLEN-1:0] mem_a_d, mem_wd_d;

    size_e           req_size_e;
    logic            accept;
    logic [XLEN:0]   last_c;
    logic            req_err_c;
    logic [XLEN-1:0] ext_raw_c;
    logic [XLEN-1:0] ext_data_c;

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid & req_ready;
    assign req_size_e = size_e'(req_size);

    // Range check on the last byte touched, widened so addresses near 2^32 cannot wrap.
    assign last_c    = {1'b0, req_addr} + 33'(size_bytes(req_size_e)) - 33'd1;
    assign req_err_c = (req_size_e == SZ_ILL)
                     | ((req_size_e == SZ_HALF) & req_addr[0])
                     | ((req_size_e == SZ_WORD) & (req_addr[1:0] != 2'b00))
                     | (last_c >= 33'(MEM_BYTES));

    assign ext_raw_c = (state_q == H1) ? {16'h0, hi_q, mem_rd[7:0]} : mem_rd;

    lsu_extend u_extend (
        .size  (req_q.size),
        .uns   (req_q.uns),
        .raw   (ext_raw_c),
        .ext_c (ext_data_c)
    );

    // Memory-side outputs are registered from the state being entered, so they are valid throughout it.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        hi_d           = hi_q;
        resp_valid_d   = 1'b0;
        resp_err_d     = 1'b0;
        resp_rdata_d   = '0;
        mem_we_d       = 1'b0;
        mem_byte_src_d = 1'b0;
        mem_a_d        = '0;
        mem_wd_d       = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d = '{we: req_we, size: req_size_e, uns: req_unsigned,
                              addr: req_addr, wdata: req_wdata};
                    if (req_err_c) begin
                        state_d = ERR;
                    end else if (req_size_e == SZ_HALF) begin
                        state_d        = H0;
                        mem_we_d       = req_we;
                        mem_byte_src_d = 1'b1;
                        mem_a_d        = req_addr;
                        mem_wd_d       = {24'h0, req_wdata[15:8]};
                    end else begin
                        state_d        = ACC;
                        mem_we_d       = req_we;
                        mem_byte_src_d = (req_size_e == SZ_BYTE);
                        mem_a_d        = req_addr;
                        mem_wd_d       = (req_size_e == SZ_BYTE) ? {24'h0, req_wdata[7:0]} : req_wdata;
                    end
                end
            end
            ACC: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = req_q.we ? '0 : ext_data_c;
            end
            H0: begin
                state_d        = H1;
                if (!req_q.we) hi_d = mem_rd[7:0];
                mem_we_d       = req_q.we;
                mem_byte_src_d = 1'b1;
                mem_a_d        = req_q.addr + 32'd1;
                mem_wd_d       = {24'h0, req_q.wdata[7:0]};
            end
            H1: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = req_q.we ? '0 : ext_data_c;
            end
            ERR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            hi_q         <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            mem_we       <= 1'b0;
            mem_byte_src <= 1'b0;
            mem_a        <= '0;
            mem_wd       <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            hi_q         <= hi_d;
            resp_valid   <= resp_valid_d;
            resp_err     <= resp_err_d;
            resp_rdata   <= resp_rdata_d;
            mem_we       <= mem_we_d;
            mem_byte_src <= mem_byte_src_d;
            mem_a        <= mem_a_d;
            mem_wd       <= mem_wd_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: byte-array reference model predicts responses, a monitor compares them.
module tb_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic        mem_byte_src;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
        int          acc;
    } exp_t;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    exp_t       sbq [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         we_cnt = 0;

    lsu dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_byte_src (mem_byte_src),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: big-endian, combinational read, posedge write.
    always_comb begin
        logic [7:0] a0;
        a0 = mem_a[7:0];
        if (mem_byte_src) mem_rd = {24'h0, mem[a0]};
        else              mem_rd = {mem[a0], mem[a0 + 8'd1], mem[a0 + 8'd2], mem[a0 + 8'd3]};
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        forever begin
            @(posedge clk);
            if (mem_we) begin
                if (mem_byte_src) mem[mem_a[7:0]] <= mem_wd[7:0];
                else for (int k = 0; k < 4; k++) mem[8'(int'(mem_a[7:0]) + k)] <= 8'(mem_wd >> (24 - 8 * k));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour from the access rules: byte array, big-endian, arithmetic extension.
    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        longint unsigned n, last, v;
        n      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last   = 64'(addr) + n - 1;
        e.err  = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0) || (last >= 256);
        e.lat  = (!e.err && sz == 2'd1) ? 3 : 2;
        e.wes  = (!e.err && we) ? ((sz == 2'd1) ? 2 : 1) : 0;
        e.rdata = 32'h0;
        e.acc  = 0;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++)
                    ref_mem[int'(addr) + i] = 8'(64'(wd) >> (8 * (int'(n) - 1 - i)));
            end else begin
                v = 0;
                for (int i = 0; i < int'(n); i++) v = v * 256 + 64'(ref_mem[int'(addr) + i]);
                if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1)))
                    v = v + (64'd1 << 32) - (64'd1 << (8 * n));
                e.rdata = 32'(v);
            end
        end
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (mem_we) we_cnt++;
                if (resp_valid) begin
                    chk("we_during_resp", 32'(mem_we), 32'h0);
                    if (sbq.size() == 0) begin
                        chk("unexpected_resp", 32'(resp_valid), 32'h0);
                    end else begin
                        e = sbq.pop_front();
                        chk("rdata", resp_rdata, e.rdata);
                        chk("err", 32'(resp_err), 32'(e.err));
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                        chk("mem_we_cycles", 32'(we_cnt), 32'(e.wes));
                    end
                    we_cnt = 0;
                end
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'h1);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        e = model(we, sz, uns, addr, wd);
        @(posedge clk);
        #1;
        e.acc     = cyc;
        sbq.push_back(e);
        req_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (sbq.size() != 0) begin
            chk("resp_timeout", 32'(sbq.size()), 32'h0);
            sbq.delete();
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic [7:0]  old31;
        int          r;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {28'h0, resp_valid, resp_err, mem_we, mem_byte_src}, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'h1);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h20, 32'h00008001);
        chk("half_hi_byte", 32'(mem[8'h20]), 32'h80);
        chk("half_lo_byte", 32'(mem[8'h21]), 32'h01);
        issue(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234);
        issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'hFE, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'hFC, 32'hA1B2C3D4);
        chk("last_word_byte", 32'(mem[8'hFF]), 32'hD4);
        issue(1'b0, 2'd1, 1'b0, 32'hFFFFFFFE, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'hFF, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);

        for (int t = 0; t < 200; t++) begin
            r  = int'($urandom_range(0, 9));
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if (r <= 6)      a = (sz == 2'd1) ? (a & ~32'h1) : (sz == 2'd2) ? (a & ~32'h3) : a;
            else if (r == 8) a = 32'($urandom_range(32'hF8, 32'h104));
            else if (r == 9) a = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Half store interrupted by reset while in its second byte access.
        old31 = mem[8'h31];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h0000ABCD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_ctrl", {28'h0, resp_valid, resp_err, mem_we, mem_byte_src}, 32'h0);
        chk("midrst_mem_a", mem_a, 32'h0);
        chk("midrst_mem_wd", mem_wd, 32'h0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        we_cnt = 0;
        ref_mem[8'h30] = 8'hAB;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready), 32'h1);
        chk("midrst_byte30", 32'(mem[8'h30]), 32'hAB);
        chk("midrst_byte31", 32'(mem[8'h31]), 32'(old31));
        repeat (5) @(negedge clk);

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("mem_image", 32'(bad), 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
